// File: rtl/instruction_cache_fill_pkg.sv
// Shared types and constants for the instruction cache miss/fill controller.
//   icache_fill_state_t : fill FSM state encoding
//   ICACHE_BEATS        : bus beats per cache line
//   ICACHE_BEAT_BYTES   : bytes carried by one bus beat
package instruction_cache_fill_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQUEST = 3'd1,
    RECEIVE = 3'd2,
    DONE    = 3'd3,
    RELEASE = 3'd4
  } icache_fill_state_t;

  localparam int ICACHE_BEATS      = 4;
  localparam int ICACHE_BEAT_BYTES = 4;

endpackage

// File: rtl/instruction_cache_fill_line_buffer.sv
// Line assembly buffer: BEATS words of BUS_WIDTH bits, one word written per
// response beat, whole line read flat (word k in bits [BUS_WIDTH*k +: BUS_WIDTH]).
// Ports:
//   clock, reset  : clock and synchronous active-high reset (clears storage)
//   write_enable  : store write_data into word write_index this cycle
//   write_index   : destination word
//   write_data    : response beat data
//   line          : registered flat view of all words
module instruction_cache_line_buffer
  import instruction_cache_fill_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int BEATS     = ICACHE_BEATS
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         write_enable,
  input  logic [$clog2(BEATS)-1:0]     write_index,
  input  logic [BUS_WIDTH-1:0]         write_data,
  output logic [BUS_WIDTH*BEATS-1:0]   line
);

  logic [BUS_WIDTH-1:0] words [BEATS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < BEATS; k++) begin
        words[k] <= '0;
      end
    end else if (write_enable) begin
      words[write_index] <= write_data;
    end
  end

  always_comb begin
    line = '0;
    for (int k = 0; k < BEATS; k++) begin
      line[k*BUS_WIDTH +: BUS_WIDTH] = words[k];
    end
  end

endmodule

// File: rtl/instruction_cache_fill.sv
// Instruction cache miss/fill controller. Takes a line miss from the fetch
// pipeline, reads the line as BEATS pipelined bus reads, assembles it and
// presents it on miss_data with a one-cycle done pulse.
// Build option: ICACHE_CRITICAL_WORD_FIRST_EN -- when defined, beats are
// issued starting at the missed word and wrap; otherwise word 0 first.
// Line placement is identical in both builds.
// Ports:
//   clock, reset        : sole clock, synchronous active-high reset
//   miss, miss_address  : level miss request and missing byte address
//   miss_data, done     : assembled line, valid in the single done cycle
//   mem_address/mem_read/mem_waitrequest : bus request channel
//   mem_readdata/mem_readdatavalid       : in-order response channel
//   fill_state          : current FSM state (debug visibility)
// Bus handshake: a request beat is transferred on any cycle where
// mem_read=1 and mem_waitrequest=0; while mem_waitrequest=1 the request
// (mem_read, mem_address) is held unchanged. Each mem_readdatavalid cycle
// delivers one response, in issue order, and cannot be back-pressured.
module instruction_cache_fill
  import instruction_cache_fill_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 128,
  parameter int BUS_WIDTH    = 32,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  miss,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  output logic [DATA_WIDTH-1:0] miss_data,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_read,
  input  logic                  mem_waitrequest,
  input  logic [BUS_WIDTH-1:0]  mem_readdata,
  input  logic                  mem_readdatavalid,
  output icache_fill_state_t    fill_state
);

  localparam int BEATS = DATA_WIDTH / BUS_WIDTH;
  localparam int WI    = $clog2(BEATS);
  localparam int CW    = WI + 1;
  localparam logic [CW-1:0] ALL_BEATS = CW'(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  icache_fill_state_t    state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [WI-1:0]         start_q, start_d;
  logic [CW-1:0]         issue_q, issue_d;
  logic [CW-1:0]         recv_q, recv_d;
  logic                  mem_read_d;
  logic [ADDR_WIDTH-1:0] mem_address_d;
  logic                  done_d;
  logic [WI-1:0]         issue_word;
  logic                  accept;
  logic                  response;
  logic [WI-1:0]         write_index;
  logic                  unused_offset;

  // Byte-offset bits never select a beat on their own.
  assign unused_offset = ^miss_address[OFFSET_WIDTH-1:0];

  assign accept   = mem_read && !mem_waitrequest;
  // Responses outside REQUEST/RECEIVE (or beyond the line) are dropped.
  assign response = mem_readdatavalid && (recv_q != ALL_BEATS) &&
                    ((state_q == REQUEST) || (state_q == RECEIVE));
  assign write_index = start_q + recv_q[WI-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      start_q     <= '0;
      issue_q     <= '0;
      recv_q      <= '0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      start_q     <= start_d;
      issue_q     <= issue_d;
      recv_q      <= recv_d;
      mem_read    <= mem_read_d;
      mem_address <= mem_address_d;
      done        <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    start_d = start_q;
    issue_d = issue_q;
    recv_d  = recv_q;

    if (accept && (issue_q != ALL_BEATS)) issue_d = issue_q + 1'b1;
    if (response)                         recv_d  = recv_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        issue_d = '0;
        recv_d  = '0;
        if (miss) begin
          base_d  = {miss_address[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
          start_d = miss_address[OFFSET_WIDTH-1:2];
`else
          start_d = '0;
`endif
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        // The last response can land in the same cycle as the last issue
        // only with zero-latency memory; DONE wins either way.
        if (response && (recv_q == LAST_BEAT)) state_d = DONE;
        else if (issue_d == ALL_BEATS)         state_d = RECEIVE;
      end
      RECEIVE: begin
        if (response && (recv_q == LAST_BEAT)) state_d = DONE;
      end
      DONE:    state_d = RELEASE;
      // A miss still held after done must drop before another fill starts.
      RELEASE: if (!miss) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are computed from the next state.
    mem_read_d    = (state_d == REQUEST) && (issue_d != ALL_BEATS);
    issue_word    = start_d + issue_d[WI-1:0];
    mem_address_d = mem_read_d ? base_d + ADDR_WIDTH'({issue_word, 2'b00})
                               : mem_address;
    done_d        = (state_d == DONE);
  end

  assign fill_state = state_q;

  instruction_cache_line_buffer #(
    .BUS_WIDTH (BUS_WIDTH),
    .BEATS     (BEATS)
  ) u_line_buffer (
    .clock        (clock),
    .reset        (reset),
    .write_enable (response),
    .write_index  (write_index),
    .write_data   (mem_readdata),
    .line         (miss_data)
  );

endmodule

// File: tb/tb_instruction_cache_fill.sv
// Testbench for instruction_cache_fill. A memory model answers each accepted
// read one cycle later with its own address as data; expected lines are
// queued when a miss is driven and checked when done pulses.
module tb_instruction_cache_fill;
  import instruction_cache_fill_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset;
  logic               miss;
  logic [31:0]        miss_address;
  logic [127:0]       miss_data;
  logic               done;
  logic [31:0]        mem_address;
  logic               mem_read;
  logic               mem_waitrequest;
  logic [31:0]        mem_readdata;
  logic               mem_readdatavalid;
  icache_fill_state_t fill_state;

  instruction_cache_fill dut (
    .clock             (clock),
    .reset             (reset),
    .miss              (miss),
    .miss_address      (miss_address),
    .miss_data         (miss_data),
    .done              (done),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .fill_state        (fill_state)
  );

  // ---------------- scoreboard state ----------------
  int n_compared   = 0;
  int n_mismatched = 0;
  logic [127:0] exp_q[$];
  logic [31:0]  acc_q[$];
  logic [31:0]  stall_q[$];
  int acc_count   = 0;
  int rsp_count   = 0;
  int stall_after = -1;
  int stall_left  = 0;
  bit spurious    = 1'b0;
  int mr_first, mr_last, mr_count;

  function automatic logic [127:0] exp_line(input logic [31:0] base);
    return {base + 32'hC, base + 32'h8, base + 32'h4, base};
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] a, input int i);
    logic [1:0] s;
    logic [1:0] w;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    s = a[3:2];
`else
    s = 2'd0;
`endif
    w = s + 2'(i);
    return {a[31:4], 4'h0} + {28'h0, w, 2'b00};
  endfunction

  // ---------------- memory model (latency 1) ----------------
  bit          pend_valid = 1'b0;
  logic [31:0] pend_addr  = '0;
  initial begin
    mem_waitrequest   = 1'b0;
    mem_readdatavalid = 1'b0;
    mem_readdata      = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pend_valid        = 1'b0;
        mem_waitrequest   = 1'b0;
        mem_readdatavalid = 1'b0;
        mem_readdata      = '0;
      end else begin
        mem_waitrequest = mem_read && (acc_count == stall_after) && (stall_left > 0);
        if (mem_waitrequest) begin
          stall_left--;
          stall_q.push_back(mem_address);
        end
        if (pend_valid) begin
          mem_readdatavalid = 1'b1;
          mem_readdata      = pend_addr;
          rsp_count++;
        end else if (spurious) begin
          mem_readdatavalid = 1'b1;
          mem_readdata      = 32'hDEAD_BEEF;
        end else begin
          mem_readdatavalid = 1'b0;
          mem_readdata      = '0;
        end
        pend_valid = mem_read && !mem_waitrequest;
        pend_addr  = mem_address;
        if (pend_valid) begin
          acc_q.push_back(mem_address);
          acc_count++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_bus_log();
    acc_q.delete();
    stall_q.delete();
    acc_count = 0;
    rsp_count = 0;
  endtask

  // Called at a negedge; drives a miss and runs until done or budget expiry.
  task automatic run_fill(input logic [31:0] addr, output int done_cycle,
                          output logic [127:0] line);
    int dc;
    dc   = -1;
    line = '0;
    miss = 1'b1;
    miss_address = addr;
    exp_q.push_back(exp_line({addr[31:4], 4'h0}));
    mr_first = -1; mr_last = -1; mr_count = 0;
    for (int k = 1; k <= 40 && dc < 0; k++) begin
      @(negedge clock);
      if (k == 1) miss_address = 32'hFFFF_FFF0;  // must be ignored once latched
      if (mem_read) begin
        if (mr_first < 0) mr_first = k;
        mr_last = k;
        mr_count++;
      end
      if (done) begin
        dc   = k;
        line = miss_data;
      end
    end
    done_cycle = dc;
  endtask

  task automatic drop_miss();
    @(negedge clock);
    miss = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; miss = 1'b0; miss_address = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("FAIL reset_done: got %b want 0", done); end
    n_compared++; if (mem_read !== 1'b0) begin n_mismatched++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
    n_compared++; if (mem_address !== 32'h0) begin n_mismatched++; $display("FAIL reset_mem_address: got %h want 0", mem_address); end
    n_compared++; if (miss_data !== 128'h0) begin n_mismatched++; $display("FAIL reset_miss_data: got %h want 0", miss_data); end
    n_compared++; if (fill_state !== IDLE) begin n_mismatched++; $display("FAIL reset_state: got %0d want %0d", fill_state, IDLE); end
    clear_bus_log();
  endtask

  task automatic test_basic_fill();
    int dc; logic [127:0] line, exp; logic [31:0] got, want;
    clear_bus_log();
    run_fill(32'h0000_1234, dc, line);
    exp = exp_q.pop_front();
    n_compared++; if (line !== exp) begin n_mismatched++; $display("FAIL basic_line: got %h want %h", line, exp); end
    n_compared++; if (dc !== 6) begin n_mismatched++; $display("FAIL basic_done_cycle: got %0d want 6", dc); end
    n_compared++; if (mr_first !== 1 || mr_last !== 4 || mr_count !== 4) begin n_mismatched++; $display("FAIL basic_mem_read_window: got %0d..%0d (%0d) want 1..4 (4)", mr_first, mr_last, mr_count); end
    for (int i = 0; i < 4; i++) begin
      got  = (acc_q.size() > 0) ? acc_q.pop_front() : 32'hxxxx_xxxx;
      want = exp_addr(32'h0000_1234, i);
      n_compared++; if (got !== want) begin n_mismatched++; $display("FAIL basic_addr%0d: got %h want %h", i, got, want); end
    end
    @(negedge clock);
    n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("FAIL basic_done_width: got %b want 0", done); end
    miss = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_stall();
    int dc; logic [127:0] line, exp; logic [31:0] got, want;
    clear_bus_log();
    stall_after = 1; stall_left = 3;
    run_fill(32'h0000_1234, dc, line);
    stall_after = -1;
    exp = exp_q.pop_front();
    n_compared++; if (line !== exp) begin n_mismatched++; $display("FAIL stall_line: got %h want %h", line, exp); end
    n_compared++; if (dc !== 9) begin n_mismatched++; $display("FAIL stall_done_cycle: got %0d want 9", dc); end
    n_compared++; if (stall_q.size() !== 3) begin n_mismatched++; $display("FAIL stall_wait_cycles: got %0d want 3", stall_q.size()); end
    want = exp_addr(32'h0000_1234, 1);
    while (stall_q.size() > 0) begin
      got = stall_q.pop_front();
      n_compared++; if (got !== want) begin n_mismatched++; $display("FAIL stall_held_addr: got %h want %h", got, want); end
    end
    n_compared++; if (acc_count !== 4) begin n_mismatched++; $display("FAIL stall_accepted: got %0d want 4", acc_count); end
    for (int i = 0; i < 4; i++) begin
      got  = (acc_q.size() > 0) ? acc_q.pop_front() : 32'hxxxx_xxxx;
      want = exp_addr(32'h0000_1234, i);
      n_compared++; if (got !== want) begin n_mismatched++; $display("FAIL stall_addr%0d: got %h want %h", i, got, want); end
    end
    drop_miss();
  endtask

  task automatic test_critical_word();
    int dc; logic [127:0] line, exp; logic [31:0] got, want;
    clear_bus_log();
    run_fill(32'h0000_123C, dc, line);
    exp = exp_q.pop_front();
    n_compared++; if (line !== exp_line(32'h0000_1230)) begin n_mismatched++; $display("FAIL cwf_line: got %h want %h", line, exp); end
    n_compared++; if (dc !== 6) begin n_mismatched++; $display("FAIL cwf_done_cycle: got %0d want 6", dc); end
    for (int i = 0; i < 4; i++) begin
      got  = (acc_q.size() > 0) ? acc_q.pop_front() : 32'hxxxx_xxxx;
      want = exp_addr(32'h0000_123C, i);
      n_compared++; if (got !== want) begin n_mismatched++; $display("FAIL cwf_addr%0d: got %h want %h", i, got, want); end
    end
    drop_miss();
  endtask

  task automatic test_reset_mid_fill();
    int dc; bit seen; logic [127:0] line, exp;
    clear_bus_log();
    miss = 1'b1; miss_address = 32'h0000_1234;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clock); #1;
      if (rsp_count >= 2) seen = 1'b1;
    end
    n_compared++; if (!seen) begin n_mismatched++; $display("FAIL rst_mid_responses: got %0d want 2", rsp_count); end
    @(negedge clock);
    reset = 1'b1; miss = 1'b0;
    @(negedge clock);
    n_compared++; if (mem_read !== 1'b0) begin n_mismatched++; $display("FAIL rst_mid_mem_read: got %b want 0", mem_read); end
    n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("FAIL rst_mid_done: got %b want 0", done); end
    n_compared++; if (miss_data !== 128'h0) begin n_mismatched++; $display("FAIL rst_mid_miss_data: got %h want 0", miss_data); end
    n_compared++; if (fill_state !== IDLE) begin n_mismatched++; $display("FAIL rst_mid_state: got %0d want %0d", fill_state, IDLE); end
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    clear_bus_log();
    run_fill(32'h0000_2000, dc, line);
    exp = exp_q.pop_front();
    n_compared++; if (line !== exp) begin n_mismatched++; $display("FAIL rst_mid_refill_line: got %h want %h", line, exp); end
    n_compared++; if (dc !== 6) begin n_mismatched++; $display("FAIL rst_mid_refill_cycle: got %0d want 6", dc); end
    drop_miss();
  endtask

  task automatic test_held_miss();
    int dc, reads, dones, bad_data; logic [127:0] line, exp;
    clear_bus_log();
    run_fill(32'h0000_3000, dc, line);
    exp = exp_q.pop_front();
    n_compared++; if (line !== exp) begin n_mismatched++; $display("FAIL held_line: got %h want %h", line, exp); end
    reads = 0; dones = 0; bad_data = 0;
    spurious = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (mem_read) reads++;
      if (done) dones++;
      if (miss_data !== exp) bad_data++;
    end
    n_compared++; if (fill_state !== RELEASE) begin n_mismatched++; $display("FAIL held_state: got %0d want %0d", fill_state, RELEASE); end
    miss = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (mem_read) reads++;
      if (done) dones++;
      if (miss_data !== exp) bad_data++;
    end
    spurious = 1'b0;
    @(negedge clock);
    n_compared++; if (reads !== 0) begin n_mismatched++; $display("FAIL held_no_read: got %0d read cycles want 0", reads); end
    n_compared++; if (dones !== 0) begin n_mismatched++; $display("FAIL held_no_done: got %0d done cycles want 0", dones); end
    n_compared++; if (bad_data !== 0) begin n_mismatched++; $display("FAIL held_line_kept: got %0d changed cycles want 0", bad_data); end
    n_compared++; if (fill_state !== IDLE) begin n_mismatched++; $display("FAIL held_back_idle: got %0d want %0d", fill_state, IDLE); end
  endtask

  task automatic test_back_to_back();
    int dc1, dc2; logic [127:0] l1, l2, e1, e2; logic [31:0] got, want;
    clear_bus_log();
    run_fill(32'h0000_1000, dc1, l1);
    @(negedge clock);
    miss = 1'b0;
    @(negedge clock);
    clear_bus_log();
    run_fill(32'h0000_2010, dc2, l2);
    e1 = exp_q.pop_front();
    e2 = exp_q.pop_front();
    n_compared++; if (l1 !== e1) begin n_mismatched++; $display("FAIL b2b_line1: got %h want %h", l1, e1); end
    n_compared++; if (l2 !== e2) begin n_mismatched++; $display("FAIL b2b_line2: got %h want %h", l2, e2); end
    n_compared++; if (dc1 !== 6 || dc2 !== 6) begin n_mismatched++; $display("FAIL b2b_done_cycles: got %0d,%0d want 6,6", dc1, dc2); end
    for (int i = 0; i < 4; i++) begin
      got  = (acc_q.size() > 0) ? acc_q.pop_front() : 32'hxxxx_xxxx;
      want = exp_addr(32'h0000_2010, i);
      n_compared++; if (got !== want) begin n_mismatched++; $display("FAIL b2b_addr%0d: got %h want %h", i, got, want); end
    end
    drop_miss();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_fill();
    test_stall();
    test_critical_word();
    test_reset_mid_fill();
    test_held_miss();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
